// File: rtl/float_square.sv
// Single-precision IEEE-754 squarer (z = a*a) with strobe/acknowledge handshakes.
// Multi-cycle FSM, one operand in flight; result sign is always positive.
module float_square (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [3:0] {
    GET_A, UNPACK, SPECIAL, NORMALISE_A, MULTIPLY_0, MULTIPLY_1,
    NORMALISE_1, NORMALISE_2, ROUND, PACK, PUT_Z
  } state_t;

  state_t state, state_next;

  logic [30:0]        a;
  logic [23:0]        m;
  logic signed [9:0]  e;
  logic [47:0]        p;
  logic signed [9:0]  zr;
  logic [23:0]        mant;
  logic               guard, rnd, sticky;

  logic [7:0]         a_exp;
  logic [22:0]        a_frac;
  logic               unused_sign;
  logic [47:0]        mm;
  logic signed [9:0]  zr_adj;
  logic [24:0]        mant_inc;
  logic               is_special;
  logic [31:0]        special_z;

  assign a_exp       = a[30:23];
  assign a_frac      = a[22:0];
  assign unused_sign = input_a[31];
  assign mm          = {24'd0, m} * {24'd0, m};
  assign zr_adj      = p[47] ? zr + 10'sd1 : zr;
  assign mant_inc    = {1'b0, mant} + 25'd1;

  function automatic logic round_up(input logic g, input logic r, input logic s,
                                    input logic lsb);
    return g & (r | s | lsb);
  endfunction

  function automatic logic [31:0] pack_z(input logic signed [9:0] zr_i,
                                         input logic [23:0] mant_i);
    logic [7:0] be;
    be = 8'(zr_i + 10'sd127);
    if (zr_i > 10'sd127)
      return 32'h7F80_0000;
    else if (zr_i == -10'sd126 && !mant_i[23])
      return {9'd0, mant_i[22:0]};
    else
      return {1'b0, be, mant_i[22:0]};
  endfunction

  always_comb begin
    is_special = 1'b1;
    special_z  = 32'h0000_0000;
    if (a_exp == 8'hFF && a_frac != 23'd0)
      special_z = 32'h7FC0_0000;
    else if (a_exp == 8'hFF)
      special_z = 32'h7F80_0000;
    else if (a_exp == 8'h00 && a_frac == 23'd0)
      special_z = 32'h0000_0000;
    else
      is_special = 1'b0;
  end

  always_comb begin
    state_next = state;
    case (state)
      GET_A:       if (input_a_ack && input_a_stb) state_next = UNPACK;
      UNPACK:      state_next = SPECIAL;
      SPECIAL:     state_next = is_special ? PUT_Z : NORMALISE_A;
      NORMALISE_A: if (m[23]) state_next = MULTIPLY_0;
      MULTIPLY_0:  state_next = MULTIPLY_1;
      MULTIPLY_1:  state_next = NORMALISE_1;
      NORMALISE_1: if (mant[23] || zr <= -10'sd126) state_next = NORMALISE_2;
      NORMALISE_2: if (zr >= -10'sd126) state_next = ROUND;
      ROUND:       state_next = PACK;
      PACK:        state_next = PUT_Z;
      PUT_Z:       if (output_z_stb && output_z_ack) state_next = GET_A;
      default:     state_next = GET_A;
    endcase
  end

  // control: state, handshake strobes and the held result
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= GET_A;
      input_a_ack  <= 1'b0;
      output_z_stb <= 1'b0;
      output_z     <= 32'd0;
    end else begin
      state <= state_next;
      case (state)
        GET_A:   input_a_ack <= !(input_a_ack && input_a_stb);
        SPECIAL: if (is_special) begin
          output_z     <= special_z;
          output_z_stb <= 1'b1;
        end
        PACK: begin
          output_z     <= pack_z(zr, mant);
          output_z_stb <= 1'b1;
        end
        PUT_Z: if (output_z_stb && output_z_ack) begin
          output_z_stb <= 1'b0;
          input_a_ack  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // datapath: unpack, normalise, multiply, underflow shift, round
  always_ff @(posedge clk) begin
    case (state)
      GET_A: if (input_a_ack && input_a_stb) a <= input_a[30:0];
      UNPACK: begin
        m <= {a_exp != 8'd0, a_frac};
        e <= (a_exp == 8'd0) ? -10'sd126 : $signed({2'b00, a_exp}) - 10'sd127;
      end
      NORMALISE_A: if (!m[23]) begin
        m <= {m[22:0], 1'b0};
        e <= e - 10'sd1;
      end
      MULTIPLY_0: begin
        p  <= mm;
        zr <= e <<< 1;
      end
      MULTIPLY_1: begin
        // 25+ underflow steps always round to zero, so skip the long shift.
        if (zr_adj <= -10'sd151) begin
          zr     <= -10'sd126;
          mant   <= 24'd0;
          guard  <= 1'b0;
          rnd    <= 1'b0;
          sticky <= 1'b1;
        end else if (p[47]) begin
          zr     <= zr_adj;
          mant   <= p[47:24];
          guard  <= p[23];
          rnd    <= p[22];
          sticky <= |p[21:0];
        end else begin
          zr     <= zr_adj;
          mant   <= p[46:23];
          guard  <= p[22];
          rnd    <= p[21];
          sticky <= |p[20:0];
        end
      end
      NORMALISE_1: if (!mant[23] && zr > -10'sd126) begin
        mant  <= {mant[22:0], guard};
        guard <= rnd;
        rnd   <= 1'b0;
        zr    <= zr - 10'sd1;
      end
      NORMALISE_2: if (zr < -10'sd126) begin
        mant   <= {1'b0, mant[23:1]};
        guard  <= mant[0];
        rnd    <= guard;
        sticky <= sticky | rnd;
        zr     <= zr + 10'sd1;
      end
      ROUND: if (round_up(guard, rnd, sticky, mant[0])) begin
        if (mant_inc[24]) begin
          mant <= mant_inc[24:1];
          zr   <= zr + 10'sd1;
        end else begin
          mant <= mant_inc[23:0];
        end
      end
      default: ;
    endcase
  end

endmodule
